// File: rtl/alu_issue_if.sv
// Bundles the decode-side instruction, hazard controls, forwarding sources
// and the EX-stage outputs of the ALU issue stage into one connection.
interface alu_issue_if;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        ex_valid;
  logic [4:0]  ALUConf;
  logic        Sign;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_illegal;

  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_data,
    input  ex_valid, ALUConf, Sign, in1, in2, ex_rd, ex_regwrite, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, stall, flush,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_data,
    output ex_valid, ALUConf, Sign, in1, in2, ex_rd, ex_regwrite, ex_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// ID/EX pipeline register for a MIPS-style ALU. Decodes the incoming
// instruction into ALU control and operand sources, holds it for one EX
// residency, and forwards EX/MEM and MEM/WB results onto register operands.
module alu_issue (
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);

  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_XOR = 5'd6;
  localparam logic [4:0] ALU_SLL = 5'd7;
  localparam logic [4:0] ALU_SRL = 5'd8;
  localparam logic [4:0] ALU_SRA = 5'd9;

  // Operands are kept as "register value plus index" or "constant", so
  // forwarding can be applied to register operands only. All-zero is a bubble.
  typedef struct packed {
    logic        valid;
    logic [4:0]  conf;
    logic        sign;
    logic [4:0]  rd;
    logic        regwrite;
    logic        illegal;
    logic        in1_from_rs;
    logic        in2_from_rt;
    logic [31:0] in1_const;
    logic [31:0] in2_const;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
  } stage_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  stage_t      dec;
  logic        legal;
  stage_t      st_q;
  logic [31:0] rs_val_q;
  logic [31:0] rt_val_q;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  assign op       = bus.id_instr[31:26];
  assign rs       = bus.id_instr[25:21];
  assign rt       = bus.id_instr[20:16];
  assign rd       = bus.id_instr[15:11];
  assign shamt    = bus.id_instr[10:6];
  assign funct    = bus.id_instr[5:0];
  assign imm_sext = {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
  assign imm_zext = {16'h0000, bus.id_instr[15:0]};

  // Decode the ID-stage instruction into the form stored in the EX register.
  always_comb begin
    dec             = '0;
    legal           = 1'b1;
    dec.valid       = 1'b1;
    dec.conf        = ALU_ADD;
    dec.rs_idx      = rs;
    dec.rt_idx      = rt;
    if (op == 6'h00) begin
      dec.rd          = rd;
      dec.regwrite    = 1'b1;
      dec.in1_from_rs = 1'b1;
      dec.in2_from_rt = 1'b1;
      case (funct)
        6'h20: begin dec.conf = ALU_ADD; dec.sign = 1'b1; end
        6'h21: dec.conf = ALU_ADD;
        6'h22: begin dec.conf = ALU_SUB; dec.sign = 1'b1; end
        6'h23: dec.conf = ALU_SUB;
        6'h24: dec.conf = ALU_AND;
        6'h25: dec.conf = ALU_OR;
        6'h26: dec.conf = ALU_XOR;
        6'h27: dec.conf = ALU_NOR;
        6'h2A: begin dec.conf = ALU_SLT; dec.sign = 1'b1; end
        6'h2B: dec.conf = ALU_SLT;
        6'h00: begin dec.conf = ALU_SLL; dec.in1_from_rs = 1'b0; dec.in1_const = {27'b0, shamt}; end
        6'h02: begin dec.conf = ALU_SRL; dec.in1_from_rs = 1'b0; dec.in1_const = {27'b0, shamt}; end
        6'h03: begin dec.conf = ALU_SRA; dec.in1_from_rs = 1'b0; dec.in1_const = {27'b0, shamt}; end
        6'h04: dec.conf = ALU_SLL;
        6'h06: dec.conf = ALU_SRL;
        6'h07: dec.conf = ALU_SRA;
        default: legal = 1'b0;
      endcase
    end else begin
      dec.in1_from_rs = 1'b1;
      case (op)
        6'h08: begin dec.conf = ALU_ADD; dec.sign = 1'b1; dec.in2_const = imm_sext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h09: begin dec.conf = ALU_ADD; dec.in2_const = imm_sext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h0A: begin dec.conf = ALU_SLT; dec.sign = 1'b1; dec.in2_const = imm_sext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h0B: begin dec.conf = ALU_SLT; dec.in2_const = imm_sext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h0C: begin dec.conf = ALU_AND; dec.in2_const = imm_zext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h0D: begin dec.conf = ALU_OR;  dec.in2_const = imm_zext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h0E: begin dec.conf = ALU_XOR; dec.in2_const = imm_zext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h0F: begin
          dec.conf        = ALU_SLL;
          dec.in1_from_rs = 1'b0;
          dec.in1_const   = 32'd16;
          dec.in2_const   = imm_zext;
          dec.rd          = rt;
          dec.regwrite    = 1'b1;
        end
        6'h23: begin dec.conf = ALU_ADD; dec.in2_const = imm_sext; dec.rd = rt; dec.regwrite = 1'b1; end
        6'h2B: begin dec.conf = ALU_ADD; dec.in2_const = imm_sext; end
        6'h04, 6'h05: begin dec.conf = ALU_SUB; dec.in2_from_rt = 1'b1; end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.conf    = ALU_ADD;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) begin
      dec.regwrite = 1'b0;
    end
  end

  // Pick the freshest value of each stored source register: EX/MEM first, then MEM/WB.
  always_comb begin
    fwd_rs = rs_val_q;
    fwd_rt = rt_val_q;
    if (st_q.valid && bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == st_q.rs_idx)) begin
      fwd_rs = bus.exmem_result;
    end else if (st_q.valid && bus.memwb_regwrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == st_q.rs_idx)) begin
      fwd_rs = bus.memwb_data;
    end
    if (st_q.valid && bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == st_q.rt_idx)) begin
      fwd_rt = bus.exmem_result;
    end else if (st_q.valid && bus.memwb_regwrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == st_q.rt_idx)) begin
      fwd_rt = bus.memwb_data;
    end
  end

  // EX register: flush beats stall beats load; a stall keeps absorbing retiring results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
    end else if (bus.flush) begin
      st_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
    end else if (bus.stall) begin
      rs_val_q <= fwd_rs;
      rt_val_q <= fwd_rt;
    end else if (!bus.id_valid) begin
      st_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
    end else begin
      st_q     <= dec;
      rs_val_q <= bus.id_rs_data;
      rt_val_q <= bus.id_rt_data;
    end
  end

  assign bus.ex_valid    = st_q.valid;
  assign bus.ALUConf     = st_q.conf;
  assign bus.Sign        = st_q.sign;
  assign bus.ex_rd       = st_q.rd;
  assign bus.ex_regwrite = st_q.regwrite;
  assign bus.ex_illegal  = st_q.illegal;
  assign bus.in1         = st_q.in1_from_rs ? fwd_rs : st_q.in1_const;
  assign bus.in2         = st_q.in2_from_rt ? fwd_rt : st_q.in2_const;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed literal cases followed by a
// randomized instruction stream compared every cycle against a reference model.
module tb_alu_issue;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_issue_if bus ();

  alu_issue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [4:0]  conf;
    logic        sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  // Reference model: the instruction currently in EX and its operand values.
  logic        mValid = 1'b0;
  logic [31:0] mInstr = '0;
  logic [31:0] mRs    = '0;
  logic [31:0] mRt    = '0;

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] stored);
    if (bus.exmem_regwrite && bus.exmem_rd != 5'd0 && bus.exmem_rd == idx) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 && bus.memwb_rd == idx) return bus.memwb_data;
    return stored;
  endfunction

  // What EX must show for a given instruction and stored register values.
  function automatic exp_t refExpect(input logic v, input logic [31:0] ins,
                                     input logic [31:0] rsv, input logic [31:0] rtv);
    exp_t e;
    logic [31:0] a, b, sx, zx;
    logic ok;
    e = '0;
    if (!v) return e;
    a  = fwd(ins[25:21], rsv);
    b  = fwd(ins[20:16], rtv);
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    ok = 1'b1;
    e.valid = 1'b1;
    if (ins[31:26] == 6'h00) begin
      e.rd = ins[15:11]; e.rw = 1'b1; e.in1 = a; e.in2 = b;
      case (ins[5:0])
        6'h20: begin e.conf = 2; e.sign = 1; end
        6'h21: e.conf = 2;
        6'h22: begin e.conf = 3; e.sign = 1; end
        6'h23: e.conf = 3;
        6'h24: e.conf = 0;
        6'h25: e.conf = 1;
        6'h26: e.conf = 6;
        6'h27: e.conf = 5;
        6'h2A: begin e.conf = 4; e.sign = 1; end
        6'h2B: e.conf = 4;
        6'h00: begin e.conf = 7; e.in1 = 32'(ins[10:6]); end
        6'h02: begin e.conf = 8; e.in1 = 32'(ins[10:6]); end
        6'h03: begin e.conf = 9; e.in1 = 32'(ins[10:6]); end
        6'h04: e.conf = 7;
        6'h06: e.conf = 8;
        6'h07: e.conf = 9;
        default: ok = 1'b0;
      endcase
    end else begin
      e.in1 = a; e.rd = ins[20:16]; e.rw = 1'b1;
      case (ins[31:26])
        6'h08: begin e.conf = 2; e.sign = 1; e.in2 = sx; end
        6'h09: begin e.conf = 2; e.in2 = sx; end
        6'h0A: begin e.conf = 4; e.sign = 1; e.in2 = sx; end
        6'h0B: begin e.conf = 4; e.in2 = sx; end
        6'h0C: begin e.conf = 0; e.in2 = zx; end
        6'h0D: begin e.conf = 1; e.in2 = zx; end
        6'h0E: begin e.conf = 6; e.in2 = zx; end
        6'h0F: begin e.conf = 7; e.in1 = 32'd16; e.in2 = zx; end
        6'h23: begin e.conf = 2; e.in2 = sx; end
        6'h2B: begin e.conf = 2; e.in2 = sx; e.rd = 0; e.rw = 0; end
        6'h04, 6'h05: begin e.conf = 3; e.in2 = b; e.rd = 0; e.rw = 0; end
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e = '0; e.valid = 1; e.conf = 2; e.ill = 1;
    end
    if (e.rd == 0) e.rw = 1'b0;
    return e;
  endfunction

  // Advance the model on each edge with the same flush/stall/load precedence.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mValid <= 1'b0; mInstr <= '0; mRs <= '0; mRt <= '0;
    end else if (bus.flush) begin
      mValid <= 1'b0; mInstr <= '0; mRs <= '0; mRt <= '0;
    end else if (bus.stall) begin
      if (mValid) begin
        mRs <= fwd(mInstr[25:21], mRs);
        mRt <= fwd(mInstr[20:16], mRt);
      end
    end else if (!bus.id_valid) begin
      mValid <= 1'b0; mInstr <= '0; mRs <= '0; mRt <= '0;
    end else begin
      mValid <= 1'b1; mInstr <= bus.id_instr; mRs <= bus.id_rs_data; mRt <= bus.id_rt_data;
    end
  end

  function automatic exp_t actual();
    exp_t a;
    a.valid = bus.ex_valid; a.conf = bus.ALUConf; a.sign = bus.Sign;
    a.in1 = bus.in1; a.in2 = bus.in2; a.rd = bus.ex_rd;
    a.rw = bus.ex_regwrite; a.ill = bus.ex_illegal;
    return a;
  endfunction

  // Every falling edge, compare all DUT outputs against the model.
  always @(negedge clk) begin
    exp_t e, a;
    e = refExpect(mValid, mInstr, mRs, mRt);
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL cycle_model t=%0t: got v=%0b conf=%0d s=%0b in1=%h in2=%h rd=%0d rw=%0b ill=%0b, expected v=%0b conf=%0d s=%0b in1=%h in2=%h rd=%0d rw=%0b ill=%0b",
               $time, a.valid, a.conf, a.sign, a.in1, a.in2, a.rd, a.rw, a.ill,
               e.valid, e.conf, e.sign, e.in1, e.in2, e.rd, e.rw, e.ill);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [31:0] rsd, input logic [31:0] rtd);
    bus.id_valid   = v;
    bus.id_instr   = ins;
    bus.id_rs_data = rsd;
    bus.id_rt_data = rtd;
  endtask

  task automatic setForward(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                            input logic mw, input logic [4:0] mr, input logic [31:0] md);
    bus.exmem_regwrite = ew; bus.exmem_rd = er; bus.exmem_result = ed;
    bus.memwb_regwrite = mw; bus.memwb_rd = mr; bus.memwb_data = md;
  endtask

  logic [5:0] opList [14] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
  logic [5:0] fnList [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};

  initial begin
    exp_t m;
    logic [31:0] ins;
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    setForward(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("reset_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("reset_in2", bus.in2, 32'd0);
    reset = 1'b1;

    // addi $8,$0,-5
    applyStimulus(1'b1, 32'h2008FFFB, 32'd0, 32'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    #1;
    m = refExpect(mValid, mInstr, mRs, mRt);
    checkOutput("addi_conf", 32'(bus.ALUConf), 32'd2);
    checkOutput("addi_sign", 32'(bus.Sign), 32'd1);
    checkOutput("addi_in1", bus.in1, 32'd0);
    checkOutput("addi_in2", bus.in2, 32'hFFFFFFFB);
    checkOutput("addi_rd", 32'(bus.ex_rd), 32'd8);
    checkOutput("addi_rw", 32'(bus.ex_regwrite), 32'd1);
    checkOutput("model_addi_in2", m.in2, 32'hFFFFFFFB);

    // sra $2,$3,4
    applyStimulus(1'b1, 32'h00031103, 32'd0, 32'h80000000);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    #1;
    m = refExpect(mValid, mInstr, mRs, mRt);
    checkOutput("sra_conf", 32'(bus.ALUConf), 32'd9);
    checkOutput("sra_in1", bus.in1, 32'd4);
    checkOutput("sra_in2", bus.in2, 32'h80000000);
    checkOutput("sra_rd", 32'(bus.ex_rd), 32'd2);
    checkOutput("model_sra_in1", m.in1, 32'd4);

    // lui $1,0x1234
    applyStimulus(1'b1, 32'h3C011234, 32'h0BADF00D, 32'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    #1;
    m = refExpect(mValid, mInstr, mRs, mRt);
    checkOutput("lui_conf", 32'(bus.ALUConf), 32'd7);
    checkOutput("lui_sign", 32'(bus.Sign), 32'd0);
    checkOutput("lui_in1", bus.in1, 32'h10);
    checkOutput("lui_in2", bus.in2, 32'h00001234);
    checkOutput("lui_rd", 32'(bus.ex_rd), 32'd1);
    checkOutput("model_lui_conf", 32'(m.conf), 32'd7);

    // addu $3,$5,$6 with forwarding priority on rs
    applyStimulus(1'b1, 32'h00A61821, 32'h55, 32'h66);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    setForward(1, 5, 32'h11, 1, 5, 32'h22);
    #1;
    checkOutput("fwd_exmem_in1", bus.in1, 32'h11);
    checkOutput("fwd_exmem_in2", bus.in2, 32'h66);
    setForward(0, 5, 32'h11, 1, 5, 32'h22);
    #1;
    checkOutput("fwd_memwb_in1", bus.in1, 32'h22);
    m = refExpect(mValid, mInstr, mRs, mRt);
    checkOutput("model_fwd_memwb", m.in1, 32'h22);
    setForward(1, 0, 32'h11, 1, 0, 32'h22);
    #1;
    checkOutput("fwd_rd0_in1", bus.in1, 32'h55);
    setForward(0, 0, 0, 0, 0, 0);

    // stall for two cycles while MEM/WB retires $5, then flush+stall
    applyStimulus(1'b1, 32'h00A61821, 32'h55, 32'h66);
    tick();
    applyStimulus(1'b1, 32'h2008FFFB, 32'h0, 32'h0);
    bus.stall = 1'b1;
    setForward(0, 0, 0, 1, 5, 32'h33);
    #1;
    checkOutput("stall_c1_in1", bus.in1, 32'h33);
    tick();
    setForward(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("stall_c2_in1", bus.in1, 32'h33);
    checkOutput("stall_c2_rd", 32'(bus.ex_rd), 32'd3);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    #1;
    checkOutput("flush_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("flush_in1", bus.in1, 32'd0);

    // $0 destination and illegal opcode
    applyStimulus(1'b1, 32'h00A60021, 32'h1, 32'h2);
    tick();
    applyStimulus(1'b1, 32'hFC221234, 32'h1, 32'h2);
    #1;
    checkOutput("rd0_rw", 32'(bus.ex_regwrite), 32'd0);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    #1;
    checkOutput("illegal_flag", 32'(bus.ex_illegal), 32'd1);
    checkOutput("illegal_conf", 32'(bus.ALUConf), 32'd2);
    checkOutput("illegal_in1", bus.in1, 32'd0);

    // asynchronous reset mid-cycle with a live instruction
    applyStimulus(1'b1, 32'h2008FFFB, 32'h0, 32'h0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("areset_valid", 32'(bus.ex_valid), 32'd0);
    checkOutput("areset_conf", 32'(bus.ALUConf), 32'd0);
    checkOutput("areset_in2", bus.in2, 32'd0);
    checkOutput("areset_rd", 32'(bus.ex_rd), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    #1;
    checkOutput("post_reset_capture", bus.in2, 32'hFFFFFFFB);

    // randomized stream
    for (int i = 0; i < 3000; i++) begin
      ins = {opList[$urandom_range(0, 13)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom), fnList[$urandom_range(0, 16)]};
      if ($urandom_range(0, 15) == 0) ins[15:0] = 16'($urandom);
      applyStimulus($urandom_range(0, 9) != 0, ins, $urandom, $urandom);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 11) == 0);
      setForward(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
